// File: rtl/vend_dispenser_if.sv
// Order handshake and mechanism lines between the vending FSM, the dispenser
// and the physical drop mechanism.
interface vend_dispenser_if #(
  parameter int unsigned COIN_W = 16
);
  logic              order_valid;
  logic              order_ready;
  logic [1:0]        beverage_in;
  logic [COIN_W-1:0] change_in;
  logic              mech_busy;
  logic              bev_drop;
  logic [1:0]        bev_sel;
  logic              coin_drop;
  logic [1:0]        coin_sel;
  logic              done;
  logic              err;
  logic [COIN_W-1:0] rem_out;

  // Dispenser side.
  modport slave (
    input  order_valid, beverage_in, change_in, mech_busy,
    output order_ready, bev_drop, bev_sel, coin_drop, coin_sel, done, err, rem_out
  );

  // Order source / mechanism side.
  modport master (
    output order_valid, beverage_in, change_in, mech_busy,
    input  order_ready, bev_drop, bev_sel, coin_drop, coin_sel, done, err, rem_out
  );
endinterface

// File: rtl/vend_dispenser.sv
// Vending dispenser: accepts one order, drops the beverage, then pays change
// greedily one coin per pulse while honouring the mechanism busy line.
module vend_dispenser #(
  parameter int unsigned COIN_W = 16,
  parameter int unsigned D0     = 200,
  parameter int unsigned D1     = 100,
  parameter int unsigned D2     = 50,
  parameter int unsigned D3     = 10
) (
  input  logic            clk,
  input  logic            rst,
  vend_dispenser_if.slave bus
);

  localparam logic [COIN_W-1:0] DEN0 = COIN_W'(D0);
  localparam logic [COIN_W-1:0] DEN1 = COIN_W'(D1);
  localparam logic [COIN_W-1:0] DEN2 = COIN_W'(D2);
  localparam logic [COIN_W-1:0] DEN3 = COIN_W'(D3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BEV,
    S_BEV_PULSE,
    S_CALC,
    S_COIN_PULSE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        bev_sel_q, bev_sel_d;
  logic [1:0]        coin_sel_q, coin_sel_d;
  logic [COIN_W-1:0] rem_q, rem_d;
  logic              err_q, err_d;

  // State and datapath registers; reset abandons any order in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bev_sel_q  <= '0;
      coin_sel_q <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bev_sel_q  <= bev_sel_d;
      coin_sel_q <= coin_sel_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic, order latching and greedy coin selection.
  always_comb begin
    state_d    = state_q;
    bev_sel_d  = bev_sel_q;
    coin_sel_d = coin_sel_q;
    rem_d      = rem_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.order_valid) begin
          bev_sel_d = bus.beverage_in;
          rem_d     = bus.change_in;
          err_d     = 1'b0;
          state_d   = (bus.beverage_in != 2'd0) ? S_WAIT_BEV : S_CALC;
        end
      end
      S_WAIT_BEV: begin
        if (!bus.mech_busy) state_d = S_BEV_PULSE;
      end
      S_BEV_PULSE: begin
        state_d = S_CALC;
      end
      S_CALC: begin
        if (rem_q == '0) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (rem_q < DEN3) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!bus.mech_busy) begin
          state_d = S_COIN_PULSE;
          if (rem_q >= DEN0) begin
            coin_sel_d = 2'd0;
            rem_d      = rem_q - DEN0;
          end else if (rem_q >= DEN1) begin
            coin_sel_d = 2'd1;
            rem_d      = rem_q - DEN1;
          end else if (rem_q >= DEN2) begin
            coin_sel_d = 2'd2;
            rem_d      = rem_q - DEN2;
          end else begin
            coin_sel_d = 2'd3;
            rem_d      = rem_q - DEN3;
          end
        end
      end
      S_COIN_PULSE: begin
        state_d = S_CALC;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode the state register; err/rem_out are only shown with done.
  assign bus.order_ready = (state_q == S_IDLE);
  assign bus.bev_drop    = (state_q == S_BEV_PULSE);
  assign bus.bev_sel     = bev_sel_q;
  assign bus.coin_drop   = (state_q == S_COIN_PULSE);
  assign bus.coin_sel    = coin_sel_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = (state_q == S_DONE) && err_q;
  assign bus.rem_out     = (state_q == S_DONE) ? rem_q : '0;

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser: table vectors, hand sequences for
// busy/held-valid and mid-order reset, then randomized orders against a
// greedy change model.
module tb_vend_dispenser;

  localparam int DEN [4] = '{200, 100, 50, 10};

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_q [$];

  vend_dispenser_if #(.COIN_W(16)) bus ();

  vend_dispenser #(
    .COIN_W(16),
    .D0    (200),
    .D1    (100),
    .D2    (50),
    .D3    (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bev;
    logic [15:0] chg;
    int          ncoins;
    bit          err;
    int          rem;
    int          bev_cyc;
    int          done_cyc;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Greedy change model: coin counts by integer division, fills exp_q with
  // the denomination indices in payout order, returns the unpaid remainder.
  function automatic int greedy(input int chg);
    int r;
    int n;
    r = chg;
    exp_q = {};
    for (int k = 0; k < 4; k++) begin
      n = r / DEN[k];
      for (int j = 0; j < n; j++) exp_q.push_back(k);
      r = r % DEN[k];
    end
    return r;
  endfunction

  // Run one order to completion. Negative expectations are taken from the model
  // (counts/err/rem) or skipped (latencies).
  task automatic run_order(input logic [1:0] bev, input logic [15:0] chg,
                           input int busy_n, input bit busy_rand, input bit hold,
                           input int exp_ncoins, input int exp_err, input int exp_rem,
                           input int exp_bev_cyc, input int exp_done_cyc);
    int cyc;
    bit got_done;
    bit prev_drop;
    bit cur_drop;
    int bev_cnt;
    int coin_cnt;
    int m_rem;
    int m_n;
    int done_cyc;
    m_rem = greedy(int'(chg));
    m_n   = exp_q.size();
    if (exp_ncoins < 0) exp_ncoins = m_n;
    if (exp_err < 0) exp_err = (m_rem != 0) ? 1 : 0;
    if (exp_rem < 0) exp_rem = m_rem;

    @(negedge clk);
    chk("ready_before_accept", bus.order_ready, 1);
    bus.order_valid = 1'b1;
    bus.beverage_in = bev;
    bus.change_in   = chg;
    bus.mech_busy   = 1'b0;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.order_valid = 1'b0;
      bus.beverage_in = 2'($urandom);
      bus.change_in   = 16'($urandom);
    end
    cyc = 0; got_done = 0; prev_drop = 0; bev_cnt = 0; coin_cnt = 0; done_cyc = -1;
    while (!got_done && cyc < 600) begin
      if (busy_rand) bus.mech_busy = ($urandom_range(0, 9) < 3);
      else           bus.mech_busy = ((cyc + 1) <= busy_n);
      @(negedge clk);
      cyc++;
      cur_drop = bus.bev_drop | bus.coin_drop;
      if (cur_drop) chk("drop_spacing", prev_drop, 0);
      prev_drop = cur_drop;
      if (bus.bev_drop) begin
        bev_cnt++;
        chk("bev_sel", bus.bev_sel, bev);
        if (bev_cnt == 1 && exp_bev_cyc >= 0) chk("bev_latency", cyc, exp_bev_cyc);
      end
      if (bus.coin_drop) begin
        coin_cnt++;
        chk("coin_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("coin_sel", bus.coin_sel, exp_q.pop_front());
      end
      if (bus.done) begin
        got_done = 1;
        done_cyc = cyc;
        chk("done_err", bus.err, exp_err);
        chk("done_rem", bus.rem_out, exp_rem);
        bus.order_valid = 1'b0;
      end else begin
        chk("ready_low_busy", bus.order_ready, 0);
      end
      @(posedge clk);
      #1;
    end
    bus.mech_busy   = 1'b0;
    bus.order_valid = 1'b0;
    chk("done_seen", got_done, 1);
    chk("bev_count", bev_cnt, (bev != 2'd0) ? 1 : 0);
    chk("coin_count", coin_cnt, exp_ncoins);
    chk("coins_left", exp_q.size(), 0);
    if (exp_done_cyc >= 0) chk("done_latency", done_cyc, exp_done_cyc);
    @(negedge clk);
    chk("ready_after_done", bus.order_ready, 1);
    chk("done_after_done", bus.done, 0);
  endtask

  initial begin
    vec_t vecs [9];
    bit   seen;
    logic [1:0]  rb;
    logic [15:0] rc;
    checks = 0;
    errors = 0;

    vecs[0] = '{2'd2, 16'd0,   0, 1'b0, 0, 2, 4};
    vecs[1] = '{2'd1, 16'd380, 6, 1'b0, 0, 2, 16};
    vecs[2] = '{2'd0, 16'd15,  1, 1'b1, 5, -1, 4};
    vecs[3] = '{2'd0, 16'd0,   0, 1'b0, 0, -1, 2};
    vecs[4] = '{2'd0, 16'd5,   0, 1'b1, 5, -1, 2};
    vecs[5] = '{2'd3, 16'd210, 2, 1'b0, 0, 2, 8};
    vecs[6] = '{2'd1, 16'd9,   0, 1'b1, 9, 2, 4};
    vecs[7] = '{2'd0, 16'd600, 3, 1'b0, 0, -1, 8};
    vecs[8] = '{2'd2, 16'd65,  2, 1'b1, 5, 2, 8};

    rst             = 1'b0;
    bus.order_valid = 1'b0;
    bus.beverage_in = '0;
    bus.change_in   = '0;
    bus.mech_busy   = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.order_ready, 1);
    chk("rst_bev_drop", bus.bev_drop, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", bus.order_ready, 1);
    chk("idle_bev_drop", bus.bev_drop, 0);
    chk("idle_coin_drop", bus.coin_drop, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, 0);
    chk("idle_rem_out", bus.rem_out, 0);
    chk("idle_bev_sel", bus.bev_sel, 0);
    chk("idle_coin_sel", bus.coin_sel, 0);

    // Table vectors, mechanism idle
    for (int i = 0; i < 9; i++)
      run_order(vecs[i].bev, vecs[i].chg, 0, 1'b0, 1'b0, vecs[i].ncoins,
                int'(vecs[i].err), vecs[i].rem, vecs[i].bev_cyc, vecs[i].done_cyc);

    // Busy for 5 cycles from acceptance, order_valid held throughout
    run_order(2'd3, 16'd100, 5, 1'b0, 1'b1, 1, 0, 0, 7, 11);

    // Reset mid-order after the first coin
    @(negedge clk);
    bus.order_valid = 1'b1;
    bus.beverage_in = 2'd0;
    bus.change_in   = 16'd400;
    @(posedge clk);
    #1;
    bus.order_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.coin_drop) seen = 1;
    end
    chk("rst_test_first_coin", seen, 1);
    rst = 1'b0;
    #1;
    chk("midrst_coin_drop", bus.coin_drop, 0);
    chk("midrst_ready", bus.order_ready, 1);
    chk("midrst_done", bus.done, 0);
    chk("midrst_rem_out", bus.rem_out, 0);
    chk("midrst_coin_sel", bus.coin_sel, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_drop", bus.bev_drop | bus.coin_drop, 0);
    end
    run_order(2'd1, 16'd250, 0, 1'b0, 1'b0, 2, 0, 0, 2, 8);

    // Randomized orders with random mechanism busy
    for (int i = 0; i < 40; i++) begin
      rb = 2'($urandom_range(0, 3));
      rc = 16'($urandom_range(0, 60) * 10 + (($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : 0));
      run_order(rb, rc, 0, 1'b1, 1'b0, -1, -1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
